// File: rtl/wave_reader_if.sv
// wave_reader_if -- RAM read port and output sample stream of the wave reader.
//   o_addr   reader -> RAM   read address (registered in the reader)
//   o_re     reader -> RAM   read enable, one cycle per fetch
//   i_r_data RAM -> reader   read data, sampled by the reader two edges later
//   o_sample reader -> sink  output sample
//   o_valid  reader -> sink  o_sample is valid
//   i_ready  sink -> reader  sink accepts the sample on this edge
// The reader uses the master modport; RAM/sink side uses slave.
interface wave_reader_if #(
    parameter int unsigned ADDRESS_SIZE = 8,
    parameter int unsigned DATA_SIZE    = 8
);
    logic [ADDRESS_SIZE-1:0] o_addr;
    logic                    o_re;
    logic [DATA_SIZE-1:0]    i_r_data;
    logic [DATA_SIZE-1:0]    o_sample;
    logic                    o_valid;
    logic                    i_ready;

    modport master (
        output o_addr, o_re, o_sample, o_valid,
        input  i_r_data, i_ready
    );

    modport slave (
        input  o_addr, o_re, o_sample, o_valid,
        output i_r_data, i_ready
    );
endinterface

// File: rtl/wave_reader.sv
// wave_reader -- plays a wavetable out of a synchronous RAM with a fixed-point
// phase accumulator, one sample per valid/ready transfer.
//   i_clk    clock, rising edge
//   i_res    asynchronous active-low reset
//   i_start  begin playback (only looked at while idle)
//   i_stop   abort playback
//   i_step   phase increment, ADDRESS_SIZE.FRAC_SIZE unsigned fixed point
//   i_len    table length in samples, 1..2**ADDRESS_SIZE
//   i_count  number of samples to emit, 0 = run until stopped
//   bus      RAM read port and sample stream (wave_reader_if master)
//   o_busy   high whenever not idle
//   o_done   one-cycle pulse after the last sample of a counted run
//   o_err    sticky flag: last start request had an illegal configuration
module wave_reader #(
    parameter int unsigned ADDRESS_SIZE = 8,
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned FRAC_SIZE    = 8,
    parameter int unsigned COUNT_SIZE   = 16
) (
    input  logic                              i_clk,
    input  logic                              i_res,
    input  logic                              i_start,
    input  logic                              i_stop,
    input  logic [ADDRESS_SIZE+FRAC_SIZE-1:0] i_step,
    input  logic [ADDRESS_SIZE:0]             i_len,
    input  logic [COUNT_SIZE-1:0]             i_count,
    wave_reader_if.master                     bus,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_err
);
    localparam int unsigned STEP_SIZE  = ADDRESS_SIZE + FRAC_SIZE;
    // One extra integer bit so phase + step never loses its carry before the wrap compare.
    localparam int unsigned PHASE_SIZE = ADDRESS_SIZE + 1 + FRAC_SIZE;
    localparam logic [ADDRESS_SIZE:0] LEN_MAX = {1'b1, {ADDRESS_SIZE{1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, LOAD, OUT} state_t;

    state_t                  state;
    state_t                  state_next;

    logic [STEP_SIZE-1:0]    step_q;
    logic [ADDRESS_SIZE:0]   len_q;
    logic [COUNT_SIZE-1:0]   count_q;
    logic [COUNT_SIZE-1:0]   cnt_q;
    logic [COUNT_SIZE-1:0]   cnt_inc;
    logic [PHASE_SIZE-1:0]   phase_q;
    logic [PHASE_SIZE-1:0]   phase_d;
    logic [PHASE_SIZE-1:0]   phase_sum;

    logic                    cfg_ok;
    logic                    start_req;
    logic                    accept;
    logic                    xfer;
    logic                    last;

    logic [ADDRESS_SIZE-1:0] addr_q;
    logic                    re_q;
    logic [DATA_SIZE-1:0]    sample_q;
    logic                    done_q;
    logic                    err_q;

    // Legal: 1 <= len <= 2**ADDRESS_SIZE and integer part of step < len,
    // which guarantees one subtraction always brings the phase back in range.
    assign cfg_ok    = (i_len != '0) && (i_len <= LEN_MAX) &&
                       ({1'b0, i_step[STEP_SIZE-1:FRAC_SIZE]} < i_len);
    assign start_req = (state == IDLE) && i_start && !i_stop;
    assign accept    = start_req && cfg_ok;
    assign xfer      = (state == OUT) && bus.i_ready;
    assign cnt_inc   = cnt_q + COUNT_SIZE'(1);
    assign last      = (count_q != '0) && (cnt_inc == count_q);
    assign phase_sum = phase_q + PHASE_SIZE'(step_q);

    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            phase_d = '0;
        end else if (xfer) begin
            if (phase_sum[PHASE_SIZE-1:FRAC_SIZE] >= len_q) begin
                phase_d = phase_sum - {len_q, {FRAC_SIZE{1'b0}}};
            end else begin
                phase_d = phase_sum;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = LOAD;
            LOAD:    state_next = OUT;
            OUT:     if (bus.i_ready) state_next = last ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
        // Stop overrides everything, including a transfer on the same edge.
        if (state != IDLE && i_stop) begin
            state_next = IDLE;
        end
    end

    // Outputs
    always_comb begin
        o_busy       = (state != IDLE);
        bus.o_valid  = (state == OUT);
        bus.o_re     = re_q;
        bus.o_addr   = addr_q;
        bus.o_sample = sample_q;
        o_done       = done_q;
        o_err        = err_q;
    end

    // Datapath. Read enable and address are registered from the next state so
    // they are high exactly for the ISSUE cycle without a decode after the flop.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            step_q   <= '0;
            len_q    <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            addr_q   <= '0;
            re_q     <= 1'b0;
            sample_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                step_q  <= i_step;
                len_q   <= i_len;
                count_q <= i_count;
                cnt_q   <= '0;
            end else if (xfer) begin
                cnt_q <= cnt_inc;
            end
            phase_q <= phase_d;
            re_q    <= (state_next == ISSUE);
            if (state_next == ISSUE) begin
                addr_q <= phase_d[FRAC_SIZE +: ADDRESS_SIZE];
            end
            if (state == LOAD) begin
                sample_q <= bus.i_r_data;
            end
            done_q <= xfer && last && !i_stop;
            if (start_req) begin
                err_q <= !cfg_ok;
            end
        end
    end
endmodule

// File: doc/wave_reader.md
WAVE_READER -- requirements
Module: wave_reader

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_SIZE, default 8, sample width.
REQ-003 SHALL have parameter FRAC_SIZE, default 8, fractional phase bits.
REQ-004 SHALL have parameter COUNT_SIZE, default 16, sample-counter width.
REQ-005 i_clk  in  1  single clock; all state changes on rising edge.
REQ-006 i_res  in  1  reset, asynchronous, active-low.
REQ-007 i_start  in  1  begin playback (sampled only in IDLE).
REQ-008 i_stop  in  1  abort playback.
REQ-009 i_step  in  ADDRESS_SIZE+FRAC_SIZE  phase increment (unsigned fixed point).
REQ-010 i_len  in  ADDRESS_SIZE+1  table length in samples, legal 1..2**ADDRESS_SIZE.
REQ-011 i_count  in  COUNT_SIZE  samples to emit; 0 = continuous.
REQ-012 o_addr  out  ADDRESS_SIZE  RAM read address (registered).
REQ-013 o_re  out  1  RAM read enable (registered).
REQ-014 i_r_data  in  DATA_SIZE  RAM read data.
REQ-015 o_sample  out  DATA_SIZE  output sample; o_valid  out  1; i_ready  in  1 (valid/ready stream).
REQ-016 o_busy  out  1  high in any state except IDLE; o_done  out  1  one-cycle completion pulse; o_err  out  1  sticky config error.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, LOAD, OUT.
REQ-018 IDLE: on i_start=1, i_stop=0 and legal config, latch i_step/i_len/i_count, clear phase to 0 and sample counter to 0, go to ISSUE.
REQ-019 Legal config: 1 <= i_len <= 2**ADDRESS_SIZE and integer part of i_step < i_len; on illegal start SHALL set o_err, stay IDLE.
REQ-020 ISSUE: o_re=1, o_addr=phase integer part, for exactly one cycle; next WAIT.
REQ-021 WAIT: o_re=0, one cycle; next LOAD.
REQ-022 LOAD: register i_r_data into o_sample (RAM data valid two edges after the ISSUE edge); next OUT.
REQ-023 OUT: o_valid=1, o_sample stable until the cycle with i_ready=1; transfer occurs on that edge.
REQ-024 On transfer: counter+1; phase += step; if integer part >= len, subtract len<<FRAC_SIZE (single subtraction suffices per REQ-019).
REQ-025 On transfer with i_count != 0 and counter+1 == i_count: o_done=1 for one cycle, go IDLE; otherwise go ISSUE.
REQ-026 Phase arithmetic SHALL be ADDRESS_SIZE+1+FRAC_SIZE bits wide so no carry is lost before the wrap compare.
REQ-027 Minimum sample period SHALL be 4 cycles with i_ready held high.
REQ-028 i_stop=1 in any non-IDLE state: next state IDLE, o_valid and o_re low next cycle, no o_done; stop wins over a simultaneous transfer (sample counts as transferred, no further fetch).
REQ-029 i_start while busy SHALL be ignored; i_step/i_len/i_count changes while busy SHALL have no effect.
REQ-030 o_we is not driven by this block; the block SHALL never request writes.
REQ-031 o_err SHALL clear only on reset or on a subsequent legal start.

Reset
REQ-032 i_res=0 SHALL immediately force IDLE, phase=0, counter=0, o_addr=0, o_re=0, o_sample=0, o_valid=0, o_busy=0, o_done=0, o_err=0, regardless of clock.
REQ-033 Reset asserted mid-playback SHALL abandon the in-flight read; first fetch after release requires a new i_start.

Verification
REQ-034 RAM model table[k]=k, len=8, step=1.0 (0x100), count=10, ready=1 -> samples 0..7,0,1; o_done pulse on the 10th transfer edge; period 4 cycles.
REQ-035 len=5, step=1.5 (0x180), count=6 -> addresses 0,1,3,4,1,2 (wrap at 6.0->1.0); samples match.
REQ-036 ready held low 7 cycles in OUT -> o_sample/o_valid stable, o_re stays 0, no phase advance; resumes correctly.
REQ-037 i_stop asserted in WAIT -> IDLE next cycle, o_valid never rises, o_done stays 0; new i_start restarts at address 0.
REQ-038 i_res pulsed low asynchronously between edges during OUT -> all outputs 0 immediately; step=8.0 with len=8 -> o_err=1, o_busy=0.
REQ-039 count=0, len=4, step=1.0 for 100 transfers -> repeating 0,1,2,3, o_done never asserts.
